// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multiply/divide unit: operation encodings, the
// sequencer state enum and the default operand width.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Operation select carried on the op input.
    localparam logic OP_MUL = 1'b0;   // signed multiply
    localparam logic OP_DIV = 1'b1;   // signed (truncating) divide

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : cpu_pkg

// File: rtl/add_sub.sv
// -----------------------------------------------------------------------------
// add_sub
// Combinational adder/subtractor shared by the Booth multiply and the
// restoring divide datapaths.
//
// Ports
//   a_i   in  WIDTH  first operand
//   b_i   in  WIDTH  second operand
//   sub_i in  1      0: y = a + b, 1: y = a - b
//   y_o   out WIDTH  sum or difference, modulo 2^WIDTH
// -----------------------------------------------------------------------------
module add_sub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule : add_sub

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative signed multiply (radix-2 Booth) and signed truncating divide
// (restoring, on magnitudes) producing a 2*DATA_WIDTH result for a downstream
// HI/LO register.
//
// Ports
//   clock        in   1             single clock, rising edge
//   clear_n      in   1             asynchronous active-low reset
//   start        in   1             operation request, sampled only in IDLE
//   op           in   1             OP_MUL / OP_DIV, captured with start
//   operand_a    in   DATA_WIDTH    multiplicand / dividend
//   operand_b    in   DATA_WIDTH    multiplier / divisor
//   result       out  2*DATA_WIDTH  product, or {remainder, quotient}
//   busy         out  1             operation in progress
//   done         out  1             one-cycle pulse: result valid (register enable)
//   div_by_zero  out  1             last accepted divide had operand_b == 0
//   dbg_state    out  3             current sequencer state (state_t encoding)
//
// Handshake: start is a request with no ready; it is accepted on a rising edge
// only when the unit sits in IDLE and is not in its done cycle (done low).
// Requests at any other time are dropped, never queued. done is the only
// completion indication and lasts exactly one cycle.
// -----------------------------------------------------------------------------
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic                    op,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero,
    output logic [2:0]              dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    state_t          state_q;
    logic [W:0]      acc_q;      // Booth accumulator A / divide partial remainder
    logic [W-1:0]    lo_q;       // Booth multiplier Q / dividend-then-quotient
    logic [W-1:0]    m_q;        // multiplicand / divisor magnitude
    logic            qm1_q;      // Booth q(-1) bit
    logic            q_neg_q;    // quotient must be negated
    logic            r_neg_q;    // remainder takes negative (dividend) sign
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  result_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      rem_shift;
    logic [W:0]      as_a;
    logic [W:0]      as_b;
    logic            as_sub;
    logic [W:0]      as_y;
    logic [W:0]      booth_acc;
    logic            last_iter;

    // Magnitudes are W-bit unsigned so the most negative value maps to 2^(W-1).
    assign a_mag = operand_a[W-1] ? ({W{1'b0}} - operand_a) : operand_a;
    assign b_mag = operand_b[W-1] ? ({W{1'b0}} - operand_b) : operand_b;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shift = {acc_q[W-1:0], lo_q[W-1]};

    always_comb begin
        as_a   = acc_q;
        as_b   = {m_q[W-1], m_q};          // sign-extended multiplicand
        as_sub = lo_q[0] & ~qm1_q;         // Booth pair 10 -> subtract
        if (state_q == ST_DIV) begin
            as_a   = rem_shift;
            as_b   = {1'b0, m_q};          // divisor magnitude is unsigned
            as_sub = 1'b1;
        end
    end

    add_sub #(
        .WIDTH (W + 1)
    ) u_add_sub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .y_o   (as_y)
    );

    // Booth pairs 00 and 11 leave the accumulator untouched.
    assign booth_acc = (lo_q[0] ^ qm1_q) ? as_y : acc_q;
    assign last_iter = (cnt_q == CW'(W - 1));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // done_q high means this is the done cycle: ignore start.
                    if (start && !done_q) begin
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        cnt_q  <= '0;
                        qm1_q  <= 1'b0;
                        if (op == OP_MUL) begin
                            acc_q   <= '0;
                            lo_q    <= operand_b;
                            m_q     <= operand_a;
                            state_q <= ST_MUL;
                        end else if (operand_b == '0) begin
                            // Result {dividend, all-ones} is staged for DONE.
                            acc_q   <= {operand_a[W-1], operand_a};
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            acc_q   <= '0;
                            lo_q    <= a_mag;
                            m_q     <= b_mag;
                            q_neg_q <= operand_a[W-1] ^ operand_b[W-1];
                            r_neg_q <= operand_a[W-1];
                            state_q <= ST_DIV;
                        end
                    end
                end

                ST_MUL: begin
                    // Arithmetic shift right of {A, Q, q(-1)}.
                    acc_q <= {booth_acc[W], booth_acc[W:1]};
                    lo_q  <= {booth_acc[0], lo_q[W-1:1]};
                    qm1_q <= lo_q[0];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state_q <= ST_DONE;
                    end
                end

                ST_DIV: begin
                    // Negative trial difference: restore (keep shifted value).
                    acc_q <= as_y[W] ? rem_shift : as_y;
                    lo_q  <= {lo_q[W-2:0], ~as_y[W]};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state_q <= ST_FIXUP;
                    end
                end

                ST_FIXUP: begin
                    // The remainder magnitude is below the divisor, so bit W is 0.
                    lo_q    <= q_neg_q ? ({W{1'b0}} - lo_q) : lo_q;
                    acc_q   <= {1'b0, r_neg_q ? ({W{1'b0}} - acc_q[W-1:0]) : acc_q[W-1:0]};
                    state_q <= ST_DONE;
                end

                ST_DONE: begin
                    result_q <= {acc_q[W-1:0], lo_q};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result      = result_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule : mul_div_unit

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit: a table of directed vectors, a set of
// model-checked random operations, and hand-written sequences for reset,
// start-while-busy and start-in-done-cycle behaviour.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import cpu_pkg::*;

    localparam int W  = 32;
    localparam int NV = 16;

    logic           clock;
    logic           clear_n;
    logic           start;
    logic           op;
    logic [W-1:0]   operand_a;
    logic [W-1:0]   operand_b;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [2:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {div_by_zero, result} and expected latency per operation.
    logic [2*W:0] exp_q[$];
    int           lat_q[$];

    typedef struct {
        string          name;
        logic           op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           dbz;
        int             lat;
    } vec_t;

    vec_t vecs[NV];

    mul_div_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    // Steps edges until done (bounded); optionally raises a stray start in
    // cycle 'poke' with different operands.
    task automatic wait_done(input int poke, output int lat, output bit seen, output bit busy_ok);
        lat     = 0;
        seen    = 1'b0;
        busy_ok = busy;
        while (!seen && lat < 100) begin
            if (poke != 0 && lat == poke) begin
                start     = 1'b1;
                op        = OP_DIV;
                operand_a = 32'd100;
                operand_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    // Pops the scoreboard and compares in the done cycle.
    task automatic finish_op(input string name, input int lat, input bit seen, input bit busy_ok);
        logic [2*W:0] exp_v;
        int           exp_l;
        exp_v = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        check({name, " busy while running"}, 64'(busy_ok), 64'd1);
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, lat);
        end else begin
            check({name, " latency"}, 64'(lat), 64'(exp_l));
            check({name, " result"}, result, exp_v[2*W-1:0]);
            check({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_v[2*W]));
            check({name, " busy in done cycle"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] er, input logic edz,
                          input int elat, input int poke, input bit rel);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clock);
        if (rel) clear_n = 1'b1;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        exp_q.push_back({edz, er});
        lat_q.push_back(elat);
        @(posedge clock);
        #1;
        // Scramble inputs after capture; they must have no effect.
        start     = 1'b0;
        op        = 1'($urandom_range(0, 1));
        operand_a = $urandom;
        operand_b = $urandom;
        wait_done(poke, lat, seen, busy_ok);
        finish_op(name, lat, seen, busy_ok);
        @(posedge clock);
        #1;
        check({name, " done single pulse"}, 64'(done), 64'd0);
        check({name, " result hold"}, result, er);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  lat;
        bit  seen;
        bit  busy_ok;
        bit  spurious;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ro;
        longint       sa;
        longint       sb;
        longint       qq;
        longint       rr;

        clear_n   = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;

        vecs[0]  = '{"mul_7_m3",       OP_MUL, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33};
        vecs[1]  = '{"mul_min_min",    OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33};
        vecs[2]  = '{"mul_max_max",    OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 33};
        vecs[3]  = '{"mul_zero",       OP_MUL, 32'd0,        32'h1234_5678, 64'h0,                   1'b0, 33};
        vecs[4]  = '{"mul_m1_m1",      OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1,                   1'b0, 33};
        vecs[5]  = '{"mul_min_max",    OP_MUL, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0, 33};
        vecs[6]  = '{"div_m7_2",       OP_DIV, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34};
        vecs[7]  = '{"div_5_0",        OP_DIV, 32'd5,        32'd0,        64'h0000_0005_FFFF_FFFF, 1'b1, 1};
        vecs[8]  = '{"div_min_m1",     OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34};
        vecs[9]  = '{"div_100_7",      OP_DIV, 32'd100,      32'd7,        64'h0000_0002_0000_000E, 1'b0, 34};
        vecs[10] = '{"div_7_m2",       OP_DIV, 32'd7,        32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 34};
        vecs[11] = '{"div_m7_m2",      OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 1'b0, 34};
        vecs[12] = '{"div_3_10",       OP_DIV, 32'd3,        32'd10,       64'h0000_0003_0000_0000, 1'b0, 34};
        vecs[13] = '{"div_m5_0",       OP_DIV, 32'hFFFF_FFFB, 32'd0,        64'hFFFF_FFFB_FFFF_FFFF, 1'b1, 1};
        vecs[14] = '{"div_min_min",    OP_DIV, 32'h8000_0000, 32'h8000_0000, 64'h0000_0000_0000_0001, 1'b0, 34};
        vecs[15] = '{"div_max_min",    OP_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_0000_0000, 1'b0, 34};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("reset result", result, 64'h0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));

        // Directed table; the first start coincides with reset release.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].dbz, vecs[i].lat, 0, (i == 0));
        end

        // Random operations checked against a 64-bit arithmetic model.
        for (int i = 0; i < 10; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
            if (ro == OP_DIV && rb == '0) rb = 32'd1;
            if (ro == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'h8000_0001;
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            if (ro == OP_MUL) begin
                run_op($sformatf("rand_mul%0d", i), ro, ra, rb, 64'(sa * sb), 1'b0, 33, 0, 1'b0);
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                run_op($sformatf("rand_div%0d", i), ro, ra, rb, {rr[31:0], qq[31:0]}, 1'b0, 34, 0, 1'b0);
            end
        end

        // Start while busy: stray divide-by-zero request in cycle 5 is dropped.
        run_op("busy_start", OP_MUL, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33, 5, 1'b0);

        // Start held high through the done cycle: ignored there, taken one edge later.
        @(negedge clock);
        start     = 1'b1;
        op        = OP_MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        exp_q.push_back({1'b0, 64'd81});
        lat_q.push_back(33);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(0, lat, seen, busy_ok);
        finish_op("mul_9x9", lat, seen, busy_ok);
        start     = 1'b1;
        op        = OP_MUL;
        operand_a = 32'd3;
        operand_b = 32'd4;
        exp_q.push_back({1'b0, 64'd12});
        lat_q.push_back(33);
        @(posedge clock);
        #1;
        check("done-cycle start ignored", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check("start after done accepted", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(0, lat, seen, busy_ok);
        finish_op("mul_3x4", lat, seen, busy_ok);
        @(posedge clock);
        #1;

        // Reset mid-multiply, after a divide-by-zero left flags set.
        run_op("dbz_before_reset", OP_DIV, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b1, 1, 0, 1'b0);
        @(negedge clock);
        start     = 1'b1;
        op        = OP_MUL;
        operand_a = 32'd123;
        operand_b = 32'd456;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        check("midop reset result", result, 64'h0);
        check("midop reset busy", 64'(busy), 64'd0);
        check("midop reset done", 64'(done), 64'd0);
        check("midop reset div_by_zero", 64'(div_by_zero), 64'd0);
        check("midop reset state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clock);
        clear_n  = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done || busy) spurious = 1'b1;
        end
        check("no activity after midop reset", 64'(spurious), 64'd0);
        run_op("after_reset", OP_MUL, 32'd6, 32'd7, 64'd42, 1'b0, 33, 0, 1'b0);

        // Start on the first edge after reset release.
        clear_n = 1'b0;
        run_op("start_at_release", OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 34, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mul_div_unit
